// File: rtl/slc3_pkg.sv
// Shared types and constants for the SLC-3 fetch sequencer.
// Holds the fetch state encoding, PCMUX select codes, the wait-counter width
// and the state-to-control decode used by fetch_control_unit.
package slc3_pkg;

  localparam int WAIT_CNT_W = 3;

  typedef enum logic [2:0] {
    HALTED  = 3'd0,
    S_18    = 3'd1,
    S_33    = 3'd2,
    S_35    = 3'd3,
    PAUSE_1 = 3'd4,
    PAUSE_2 = 3'd5
  } fetch_state_t;

  localparam logic [1:0] PCMUX_PC_PLUS1 = 2'b00;
  localparam logic [1:0] PCMUX_BUS      = 2'b01;
  localparam logic [1:0] PCMUX_ADDR     = 2'b10;

  // Full set of datapath/SRAM controls driven by the sequencer.
  typedef struct packed {
    logic       gate_pc;
    logic       gate_mdr;
    logic       gate_marmux;
    logic       gate_alu;
    logic       ld_pc;
    logic       ld_mar;
    logic       ld_mdr;
    logic       ld_ir;
    logic [1:0] pcmux;
    logic       mem_oe;
    logic       mem_we;
    logic       paused;
  } ctrl_t;

  // Moore decode: every control is 0 unless the state names it.
  function automatic ctrl_t decode_state(input fetch_state_t s);
    ctrl_t c;
    c = '0;
    c.pcmux = PCMUX_PC_PLUS1;
    case (s)
      S_18: begin
        c.gate_pc = 1'b1;
        c.ld_mar  = 1'b1;
        c.ld_pc   = 1'b1;
        c.pcmux   = PCMUX_PC_PLUS1;
      end
      S_33: begin
        c.mem_oe = 1'b1;
        c.ld_mdr = 1'b1;
      end
      S_35: begin
        c.gate_mdr = 1'b1;
        c.ld_ir    = 1'b1;
      end
      PAUSE_1, PAUSE_2: c.paused = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fetch_wait_counter.sv
// Dwell counter for the memory read-wait state.
// Counts up while enabled, clears on request, and flags the last wait cycle.
module fetch_wait_counter
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WAIT_CNT_W-1:0] TC_VAL = WAIT_CNT_W'(MEM_WAIT - 1);

  logic [WAIT_CNT_W-1:0] count;

  // Clear has priority so a fresh fetch always starts the dwell from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/fetch_control_unit.sv
// SLC-3 fetch sequencer: MAR<-PC / PC<-PC+1, MEM_WAIT read cycles into MDR,
// IR<-MDR, then a full Continue press/release before the next fetch.
// Optional build macro FETCH_COUNT_EN adds a 16-bit FetchCount output that
// counts completed IR loads.
module fetch_control_unit
  import slc3_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateMARMUX,
  output logic       GateALU,
  output logic       LD_PC,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic [1:0] PCMUX,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic       Paused
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0] FetchCount
`endif
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  ctrl_t        ctrl_q;
  logic         wait_tc;
  logic         wait_clr;
  logic         wait_en;

  // Dwell counter restarts on every fetch and advances only inside the read wait.
  assign wait_clr = (state == S_18) || ((state == S_33) && wait_tc);
  assign wait_en  = (state == S_33) && !wait_tc;

  fetch_wait_counter #(
    .MEM_WAIT (MEM_WAIT)
  ) u_wait (
    .clk (CLK),
    .rst (Reset),
    .clr (wait_clr),
    .en  (wait_en),
    .tc  (wait_tc)
  );

  // Next-state logic; Run matters only in HALTED, nothing returns to HALTED.
  always_comb begin
    state_nxt = state;
    case (state)
      HALTED:  if (Run) state_nxt = S_18;
      S_18:    state_nxt = S_33;
      S_33:    if (wait_tc) state_nxt = S_35;
      S_35:    state_nxt = PAUSE_1;
      PAUSE_1: if (Continue) state_nxt = PAUSE_2;
      PAUSE_2: if (!Continue) state_nxt = S_18;
      default: state_nxt = HALTED;
    endcase
  end

  // State and registered controls move together so outputs always decode the current state.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= HALTED;
      ctrl_q <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode_state(state_nxt);
    end
  end

  assign GatePC     = ctrl_q.gate_pc;
  assign GateMDR    = ctrl_q.gate_mdr;
  assign GateMARMUX = ctrl_q.gate_marmux;
  assign GateALU    = ctrl_q.gate_alu;
  assign LD_PC      = ctrl_q.ld_pc;
  assign LD_MAR     = ctrl_q.ld_mar;
  assign LD_MDR     = ctrl_q.ld_mdr;
  assign LD_IR      = ctrl_q.ld_ir;
  assign PCMUX      = ctrl_q.pcmux;
  assign Mem_OE     = ctrl_q.mem_oe;
  assign Mem_WE     = ctrl_q.mem_we;
  assign Paused     = ctrl_q.paused;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_cnt;

  // One count per IR load, i.e. per edge leaving S_35; wraps naturally.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      fetch_cnt <= '0;
    end else if (state == S_35) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

  assign FetchCount = fetch_cnt;
`endif

endmodule

// File: tb/tb_fetch_control_unit.sv
// Directed bench for fetch_control_unit with a tiny behavioural datapath/SRAM.
module tb_fetch_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       Run;
  logic       Continue;
  logic       GatePC, GateMDR, GateMARMUX, GateALU;
  logic       LD_PC, LD_MAR, LD_MDR, LD_IR;
  logic [1:0] PCMUX;
  logic       Mem_OE, Mem_WE, Paused;
`ifdef FETCH_COUNT_EN
  logic [15:0] FetchCount;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_control_unit #(.MEM_WAIT(2)) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .Run        (Run),
    .Continue   (Continue),
    .GatePC     (GatePC),
    .GateMDR    (GateMDR),
    .GateMARMUX (GateMARMUX),
    .GateALU    (GateALU),
    .LD_PC      (LD_PC),
    .LD_MAR     (LD_MAR),
    .LD_MDR     (LD_MDR),
    .LD_IR      (LD_IR),
    .PCMUX      (PCMUX),
    .Mem_OE     (Mem_OE),
    .Mem_WE     (Mem_WE),
    .Paused     (Paused)
`ifdef FETCH_COUNT_EN
    ,
    .FetchCount (FetchCount)
`endif
  );

  always #5 CLK = ~CLK;

  // Observed control vector, fixed order for the expected constants below.
  logic [12:0] obs;
  assign obs = {GatePC, GateMDR, GateMARMUX, GateALU, LD_PC, LD_MAR, LD_MDR,
                LD_IR, PCMUX, Mem_OE, Mem_WE, Paused};

  localparam logic [12:0] O_HALT  = 13'b0_0_0_0_0_0_0_0_00_0_0_0;
  localparam logic [12:0] O_S18   = 13'b1_0_0_0_1_1_0_0_00_0_0_0;
  localparam logic [12:0] O_S33   = 13'b0_0_0_0_0_0_1_0_00_1_0_0;
  localparam logic [12:0] O_S35   = 13'b0_1_0_0_0_0_0_1_00_0_0_0;
  localparam logic [12:0] O_PAUSE = 13'b0_0_0_0_0_0_0_0_00_0_0_1;

  // Behavioural datapath and SRAM driven by the sequencer's controls.
  logic [15:0] pc, mar, mdr, ir, bus;
  logic [15:0] mem [0:3];
  assign bus = GatePC ? pc : (GateMDR ? mdr : 16'h0000);

  always @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      pc  <= 16'h0000;
      mar <= 16'h0000;
      mdr <= 16'h0000;
      ir  <= 16'h0000;
    end else begin
      if (LD_MAR) mar <= bus;
      if (LD_PC)  pc  <= (PCMUX == 2'b00) ? pc + 16'd1 : bus;
      if (LD_MDR && Mem_OE) mdr <= mem[mar[1:0]];
      if (LD_IR)  ir  <= bus;
    end
  end

  // Bus contention check every cycle, away from the active edge.
  always @(negedge CLK) begin
    n_cmp++;
    assert ($onehot0({GatePC, GateMDR, GateMARMUX, GateALU})) else begin
      n_bad++;
      $error("FAIL bus_onehot observed=%b required=onehot0",
             {GatePC, GateMDR, GateMARMUX, GateALU});
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed=%h required=%h", tag, o, e);
    end
  endtask

  initial begin
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    mem[2] = 16'h9ABC;
    mem[3] = 16'hDEF0;
    Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    tick(); tick();
    chk("reset_outs", 16'(obs), 16'(O_HALT));
    Reset = 1'b0;
    tick(); chk("halted_idle", 16'(obs), 16'(O_HALT));

    // Fetch 1
    Run = 1'b1;
    tick(); chk("f1_s18", 16'(obs), 16'(O_S18));
    Run = 1'b0;
    tick(); chk("f1_s33a", 16'(obs), 16'(O_S33));
    tick(); chk("f1_s33b", 16'(obs), 16'(O_S33));
    tick(); chk("f1_s35", 16'(obs), 16'(O_S35));
    tick(); chk("f1_pause", 16'(obs), 16'(O_PAUSE));
    chk("f1_ir", ir, 16'h1234);
    chk("f1_pc", pc, 16'h0001);
    tick(); chk("f1_pause_hold", 16'(obs), 16'(O_PAUSE));
    Continue = 1'b1;
    tick(); chk("f1_pause2", 16'(obs), 16'(O_PAUSE));
    Continue = 1'b0;

    // Fetch 2
    tick(); chk("f2_s18", 16'(obs), 16'(O_S18));
    tick(); chk("f2_s33a", 16'(obs), 16'(O_S33));
    tick(); chk("f2_s33b", 16'(obs), 16'(O_S33));
    tick(); chk("f2_s35", 16'(obs), 16'(O_S35));
    tick(); chk("f2_pause", 16'(obs), 16'(O_PAUSE));
    chk("f2_ir", ir, 16'h5678);
    chk("f2_pc", pc, 16'h0002);
    Continue = 1'b1;
    tick();
    Continue = 1'b0;

    // Fetch 3 with Continue held high throughout
    tick(); chk("f3_s18", 16'(obs), 16'(O_S18));
    Continue = 1'b1;
    tick(); chk("f3_s33a", 16'(obs), 16'(O_S33));
    tick(); chk("f3_s33b", 16'(obs), 16'(O_S33));
    tick(); chk("f3_s35", 16'(obs), 16'(O_S35));
    tick(); chk("f3_pause1", 16'(obs), 16'(O_PAUSE));
    chk("f3_ir", ir, 16'h9ABC);
`ifdef FETCH_COUNT_EN
    chk("fetch_count3", FetchCount, 16'd3);
`endif
    tick(); chk("f3_pause2", 16'(obs), 16'(O_PAUSE));
    tick(); chk("f3_pause2_hold", 16'(obs), 16'(O_PAUSE));
    Continue = 1'b0;

    // Fetch 4 with Run held high: no double fetch, exit only by Continue
    Run = 1'b1;
    tick(); chk("f4_s18", 16'(obs), 16'(O_S18));
    tick(); chk("f4_s33a", 16'(obs), 16'(O_S33));
    tick(); chk("f4_s33b", 16'(obs), 16'(O_S33));
    tick(); chk("f4_s35", 16'(obs), 16'(O_S35));
    tick(); chk("f4_pause", 16'(obs), 16'(O_PAUSE));
    tick(); chk("f4_run_ignored", 16'(obs), 16'(O_PAUSE));
    Continue = 1'b1;
    tick(); chk("f4_pause2", 16'(obs), 16'(O_PAUSE));
    Continue = 1'b0;
    Run = 1'b0;

    // Reset asserted in the middle of S_33
    tick(); chk("f5_s18", 16'(obs), 16'(O_S18));
    tick(); chk("f5_s33", 16'(obs), 16'(O_S33));
    #2 Reset = 1'b1;
    #1 chk("async_reset_outs", 16'(obs), 16'(O_HALT));
    tick();
    Reset = 1'b0;
    tick(); chk("post_reset_halted", 16'(obs), 16'(O_HALT));
    chk("post_reset_oe", 16'(Mem_OE), 16'h0000);
`ifdef FETCH_COUNT_EN
    chk("fetch_count_reset", FetchCount, 16'd0);
`endif
    Run = 1'b1;
    tick(); chk("restart_s18", 16'(obs), 16'(O_S18));
    Run = 1'b0;
    tick(); chk("restart_s33", 16'(obs), 16'(O_S33));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
